// File: rtl/mem_lower_pkg.sv
// Shared helpers for lowered behavioural memories: address sizing, lane slicing
// and the init-sequencer state type.
package mem_lower_pkg;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} init_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Address ports stay at least one bit wide even for a single-word memory.
  function automatic int addr_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  function automatic int lane_count(input int width, input int gran);
    return width / gran;
  endfunction

  function automatic int lane_lo(input int lane, input int gran);
    return lane * gran;
  endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Per-lane select between an old and a new word under a lane mask; shared by the
// array update and the read-during-write forwarding path.
module mem_lane_merge
  import mem_lower_pkg::*;
#(
  parameter  int WIDTH     = 64,
  parameter  int MASK_GRAN = 8,
  localparam int MASK_W    = lane_count(WIDTH, MASK_GRAN)
) (
  input  logic [WIDTH-1:0]  old_word,
  input  logic [WIDTH-1:0]  new_word,
  input  logic [MASK_W-1:0] mask,
  output logic [WIDTH-1:0]  merged
);

  for (genvar i = 0; i < MASK_W; i++) begin : g_lane
    localparam int LO = lane_lo(i, MASK_GRAN);
    assign merged[LO +: MASK_GRAN] = mask[i] ? new_word[LO +: MASK_GRAN]
                                             : old_word[LO +: MASK_GRAN];
  end

endmodule

// File: rtl/mem_1r1w_masked_bypass.sv
// Simple-dual-port RAM with lane-masked writes, 1- or 2-cycle read pipeline,
// same-cycle write forwarding and a post-reset zero-fill sequencer.
module mem_1r1w_masked_bypass
  import mem_lower_pkg::*;
#(
  parameter  int DEPTH        = 48,
  parameter  int WIDTH        = 64,
  parameter  int MASK_GRAN    = 8,
  parameter  int READ_LATENCY = 1,
  parameter  int BYPASS       = 1,
  parameter  int INIT_ZERO    = 1,
  localparam int ADDR_W       = addr_width(DEPTH),
  localparam int MASK_W       = lane_count(WIDTH, MASK_GRAN)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] R0_addr,
  input  logic              R0_en,
  output logic [WIDTH-1:0]  R0_data,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic              W0_en,
  input  logic [WIDTH-1:0]  W0_data,
  input  logic [MASK_W-1:0] W0_mask,
  output logic              init_busy
);

  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(DEPTH - 1);
  localparam init_state_e       RST_STATE = (INIT_ZERO != 0) ? CLEAR : READY;
  localparam int                STAGES    = READ_LATENCY - 1;

  if (WIDTH % MASK_GRAN != 0) begin : g_bad_gran
    $error("mem_1r1w_masked_bypass: WIDTH must be a multiple of MASK_GRAN");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $error("mem_1r1w_masked_bypass: READ_LATENCY must be 1 or 2");
  end

  logic [WIDTH-1:0]  mem [DEPTH];
  init_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clr_we;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (cnt_q == LAST) state_d = READY;
    end
  end

  always_comb begin
    init_busy = (state_q == CLEAR);
    clr_we    = (state_q == CLEAR);
  end

  logic              r_in, w_in, wr_ok, collide;
  logic [ADDR_W-1:0] r_idx, w_idx;
  logic [WIDTH-1:0]  wr_merged, rd_word, s1_q;

  // Out-of-range addresses are folded to 0 so the array is never indexed past its end.
  assign r_in    = {1'b0, R0_addr} < DEPTH_C;
  assign w_in    = {1'b0, W0_addr} < DEPTH_C;
  assign r_idx   = r_in ? R0_addr : '0;
  assign w_idx   = w_in ? W0_addr : '0;
  assign wr_ok   = W0_en && w_in && !init_busy;
  assign collide = R0_en && r_in && wr_ok && (R0_addr == W0_addr);

  mem_lane_merge #(.WIDTH(WIDTH), .MASK_GRAN(MASK_GRAN)) u_merge (
    .old_word (mem[w_idx]),
    .new_word (W0_data),
    .mask     (W0_mask),
    .merged   (wr_merged)
  );

  always_ff @(posedge clock) begin
    if (clr_we)     mem[cnt_q] <= '0;
    else if (wr_ok) mem[w_idx] <= wr_merged;
  end

  // On a collision the merged word equals what the array will hold after this edge.
  always_comb begin
    rd_word = '0;
    if (!init_busy && r_in) rd_word = (BYPASS != 0 && collide) ? wr_merged : mem[r_idx];
  end

  logic [STAGES:0] vld_pipe;

  always_ff @(posedge clock) begin
    if (reset)            s1_q <= '0;
    else if (vld_pipe[0]) s1_q <= rd_word;
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic             vld1_q;
    logic [WIDTH-1:0] s2_q;
    assign vld_pipe = {vld1_q, R0_en};
    always_ff @(posedge clock) begin
      if (reset) begin
        vld1_q <= 1'b0;
        s2_q   <= '0;
      end else begin
        vld1_q <= vld_pipe[0];
        if (vld_pipe[1]) s2_q <= s1_q;
      end
    end
    assign R0_data = s2_q;
  end else begin : g_lat1
    assign vld_pipe = R0_en;
    assign R0_data  = s1_q;
  end

endmodule
